mem_req_initiator: RTL and testbench

Initiator-side master for the single-port 64x16 RAM request interface (req/rw/addr/Qi out; Qa/op back). Accepts host commands through a valid/ready port and buffers them in a small FIFO. Sequences each command onto the RAM port with a stable-address setup cycle, a one-cycle req pulse and a fixed-latency capture. Returns one response per command (read data or write ack) with an error flag when the RAM's op status disagrees with the command type.

---
 rtl/mem_if_pkg.sv | 27 ++
 rtl/cmd_fifo.sv | 59 +++++
 rtl/mem_req_initiator.sv | 163 ++++++++++++++++
 tb/tb_mem_req_initiator.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and encodings for the RAM request initiator.
package mem_if_pkg;

    localparam int unsigned CMD_AW = 6;
    localparam int unsigned CMD_DW = 16;

    localparam logic [1:0] OP_NONE    = 2'd0;
    localparam logic [1:0] OP_RD_DONE = 2'd1;
    localparam logic [1:0] OP_WR_DONE = 2'd2;
    localparam logic       RW_READ    = 1'b1;
    localparam logic       RW_WRITE   = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    typedef struct packed {
        logic              rw;
        logic [CMD_AW-1:0] addr;
        logic [CMD_DW-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
module cmd_fifo
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cmd_t                     wr_data,
    input  logic                     pop,
    output cmd_t                     rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;

    cmd_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == CNTW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/mem_req_initiator.sv
// Host-command initiator for the single-port RAM: FIFO-buffered commands,
// setup/issue/capture sequencing and one response per command.
module mem_req_initiator
    import mem_if_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = CMD_AW,
    parameter int unsigned DW         = CMD_DW,
    parameter int unsigned CW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_rw,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_rw,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          ram_req,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_qi,
    input  logic [DW-1:0] ram_qa,
    input  logic [1:0]    ram_op,
    output logic          busy,
    output logic [CW-1:0] err_cnt
);

    localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

    cmd_t            fifo_wdata, fifo_head;
    logic            fifo_full, fifo_empty, fifo_pop_c;
    logic [CNTW-1:0] fifo_count;
    logic            op_mismatch_c;

    state_t          state_q, state_d;
    logic            ram_req_q, ram_req_d;
    logic            ram_rw_q, ram_rw_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_qi_q, ram_qi_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_rw_q, rsp_rw_d;
    logic [AW-1:0]   rsp_addr_q, rsp_addr_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [CW-1:0]   err_cnt_q, err_cnt_d;

    assign fifo_wdata = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid),
        .wr_data (fifo_wdata),
        .pop     (fifo_pop_c),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The ram_* registers double as the current-command holding registers.
    assign op_mismatch_c = (ram_rw_q == RW_READ) ? (ram_op != OP_RD_DONE)
                                                 : (ram_op != OP_WR_DONE);

    always_comb begin
        state_d     = state_q;
        fifo_pop_c  = 1'b0;
        ram_req_d   = 1'b0;
        ram_rw_d    = ram_rw_q;
        ram_addr_d  = ram_addr_q;
        ram_qi_d    = ram_qi_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rw_d    = rsp_rw_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop_c = 1'b1;
                    ram_rw_d   = fifo_head.rw;
                    ram_addr_d = fifo_head.addr;
                    ram_qi_d   = fifo_head.wdata;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                ram_req_d = 1'b1;
                state_d   = ISSUE;
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_rw_d    = ram_rw_q;
                rsp_addr_d  = ram_addr_q;
                rsp_rdata_d = (ram_rw_q == RW_WRITE) ? '0 : ram_qa;
                rsp_err_d   = op_mismatch_c;
                if (op_mismatch_c && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CW'(1);
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ram_req_q   <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_qi_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rw_q    <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ram_req_q   <= ram_req_d;
            ram_rw_q    <= ram_rw_d;
            ram_addr_q  <= ram_addr_d;
            ram_qi_q    <= ram_qi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rw_q    <= rsp_rw_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = (state_q != IDLE) || (fifo_count != '0);
    assign ram_req   = ram_req_q;
    assign ram_rw    = ram_rw_q;
    assign ram_addr  = ram_addr_q;
    assign ram_qi    = ram_qi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rw    = rsp_rw_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Scoreboard bench for mem_req_initiator with a behavioural 64x16 RAM stub.
module tb_mem_req_initiator;

    typedef struct {
        logic        rw;
        logic [5:0]  addr;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [5:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_rw, rsp_err;
    logic [5:0]  rsp_addr;
    logic [15:0] rsp_rdata;
    logic        ram_req, ram_rw;
    logic [5:0]  ram_addr;
    logic [15:0] ram_qi, ram_qa;
    logic [1:0]  ram_op;
    logic        busy;
    logic [7:0]  err_cnt;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks;
    int          errors;
    int          rsp_cnt;
    int          req_run;
    logic [15:0] ref_mem [64];
    logic [15:0] ram_mem [64];
    logic        force_en;
    logic [1:0]  force_op;

    mem_req_initiator dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rw    (rsp_rw),
        .rsp_addr  (rsp_addr),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_req   (ram_req),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_qi    (ram_qi),
        .ram_qa    (ram_qa),
        .ram_op    (ram_op),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM stub: acts on the req edge, status valid for the following cycle.
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_rw) begin
                ram_qa <= ram_mem[ram_addr];
                ram_op <= force_en ? force_op : 2'd1;
            end else begin
                ram_mem[ram_addr] <= ram_qi;
                ram_op <= force_en ? force_op : 2'd2;
            end
        end else begin
            ram_op <= 2'd0;
        end
    end

    // Response scoreboard and req pulse-width monitor.
    always @(negedge clk) begin
        if (rst && ram_req) begin
            req_run = req_run + 1;
        end else if (req_run != 0) begin
            checks = checks + 1;
            if (req_run != 1) begin
                errors = errors + 1;
                $display("FAIL req_pulse_width got=%0d want=1", req_run);
            end
            req_run = 0;
        end
        if (rst && rsp_valid && rsp_ready) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL rsp_unexpected rw=%0b addr=%h rdata=%h", rsp_rw, rsp_addr, rsp_rdata);
            end else begin
                mon_e = sb.pop_front();
                rsp_cnt = rsp_cnt + 1;
                if ({rsp_rw, rsp_addr, rsp_rdata, rsp_err} !== {mon_e.rw, mon_e.addr, mon_e.rdata, mon_e.err}) begin
                    errors = errors + 1;
                    $display("FAIL rsp_data got rw=%0b addr=%h rdata=%h err=%0b want rw=%0b addr=%h rdata=%h err=%0b",
                             rsp_rw, rsp_addr, rsp_rdata, rsp_err, mon_e.rw, mon_e.addr, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rw, input logic [5:0] addr, input logic [15:0] wd, input logic exp_err);
        exp_t e;
        int   n;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL cmd_ready_timeout got=0 want=1 addr=%h", addr);
        end else begin
            e.rw    = rw;
            e.addr  = addr;
            e.rdata = rw ? ref_mem[addr] : 16'h0000;
            e.err   = exp_err;
            if (!rw) ref_mem[addr] = wd;
            sb.push_back(e);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output logic timed_out);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        timed_out = (sb.size() != 0 || busy);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks = checks + 1;
        if ({rsp_valid, ram_req, busy, err_cnt, rsp_rdata, ram_addr} !== 32'h0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs got valid=%0b req=%0b busy=%0b errcnt=%h rdata=%h addr=%h want all 0",
                     rsp_valid, ram_req, busy, err_cnt, rsp_rdata, ram_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks = checks + 1;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_release got ready=%0b busy=%0b want ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_read();
        logic to;
        send(1'b0, 6'h02, 16'hAAAA, 1'b0);
        send(1'b1, 6'h02, 16'h0000, 1'b0);
        wait_idle(100, to);
        checks = checks + 1;
        if (to) begin
            errors = errors + 1;
            $display("FAIL write_read_drain got pending=%0d want 0", sb.size());
        end
    endtask

    task automatic test_latency();
        logic to;
        send(1'b0, 6'h24, 16'h5A55, 1'b0);
        tick();
        tick();
        tick();
        checks = checks + 1;
        if (rsp_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL latency_early got rsp_valid=%0b want 0 at t0+3", rsp_valid);
        end
        tick();
        checks = checks + 1;
        if (rsp_valid !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL latency_t4 got rsp_valid=%0b want 1 at t0+4", rsp_valid);
        end
        send(1'b1, 6'h24, 16'h0000, 1'b0);
        send(1'b1, 6'h00, 16'h0000, 1'b0);
        wait_idle(100, to);
        checks = checks + 1;
        if (to) begin
            errors = errors + 1;
            $display("FAIL latency_drain got pending=%0d want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic to;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, 6'(8 + i), 16'(16'h1100 + i), 1'b0);
        for (int i = 0; i < 6; i++) tick();
        checks = checks + 1;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_addr !== 6'h08) begin
            errors = errors + 1;
            $display("FAIL backpressure got ready=%0b valid=%0b addr=%h want ready=0 valid=1 addr=08",
                     cmd_ready, rsp_valid, rsp_addr);
        end
        rsp_ready = 1'b1;
        send(1'b1, 6'h0A, 16'h0000, 1'b0);
        wait_idle(200, to);
        checks = checks + 1;
        if (to || rsp_cnt != 11) begin
            errors = errors + 1;
            $display("FAIL back_to_back_count got rsp=%0d pending=%0d want rsp=11 pending=0", rsp_cnt, sb.size());
        end
    endtask

    task automatic test_err();
        logic to;
        force_en = 1'b1;
        force_op = 2'd2;
        send(1'b1, 6'h05, 16'h0000, 1'b1);
        wait_idle(100, to);
        checks = checks + 1;
        if (to || err_cnt !== 8'd1) begin
            errors = errors + 1;
            $display("FAIL err_first got err_cnt=%0d want 1", err_cnt);
        end
        force_op = 2'd1;
        send(1'b0, 6'h05, 16'h0BAD, 1'b1);
        wait_idle(100, to);
        checks = checks + 1;
        if (to || err_cnt !== 8'd2) begin
            errors = errors + 1;
            $display("FAIL err_write got err_cnt=%0d want 2", err_cnt);
        end
        force_op = 2'd2;
        for (int i = 0; i < 260; i++) send(1'b1, 6'h05, 16'h0000, 1'b1);
        wait_idle(200, to);
        checks = checks + 1;
        if (to || err_cnt !== 8'hFF) begin
            errors = errors + 1;
            $display("FAIL err_saturate got err_cnt=%h want ff", err_cnt);
        end
        force_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic to;
        logic saw_valid;
        int   n;
        send(1'b1, 6'h24, 16'h0000, 1'b0);
        n = 0;
        while (!ram_req && n < 20) begin
            tick();
            n++;
        end
        rst = 1'b0;
        #1;
        sb.delete();
        checks = checks + 1;
        if (ram_req !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'h00 || n >= 20) begin
            errors = errors + 1;
            $display("FAIL reset_mid got req=%0b valid=%0b busy=%0b errcnt=%h waited=%0d want all 0",
                     ram_req, rsp_valid, busy, err_cnt, n);
        end
        @(negedge clk);
        rst = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) saw_valid = 1'b1;
        end
        checks = checks + 1;
        if (saw_valid !== 1'b0 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_abort got saw_valid=%0b busy=%0b want 0 0", saw_valid, busy);
        end
        send(1'b0, 6'h31, 16'hC3C3, 1'b0);
        send(1'b1, 6'h31, 16'h0000, 1'b0);
        wait_idle(100, to);
        checks = checks + 1;
        if (to) begin
            errors = errors + 1;
            $display("FAIL reset_recover got pending=%0d want 0", sb.size());
        end
    endtask

    task automatic test_wrap();
        logic       to;
        int         base;
        logic [5:0] a;
        base = rsp_cnt;
        for (int i = 0; i < 9; i++) begin
            a = 6'((i * 7) % 64);
            send(1'b0, a, 16'(16'h3000 + i * 16'h0111), 1'b0);
            send(1'b1, a, 16'h0000, 1'b0);
        end
        wait_idle(300, to);
        checks = checks + 1;
        if (to || busy !== 1'b0 || cmd_ready !== 1'b1 || (rsp_cnt - base) != 18) begin
            errors = errors + 1;
            $display("FAIL wrap got busy=%0b ready=%0b rsp=%0d want busy=0 ready=1 rsp=18",
                     busy, cmd_ready, rsp_cnt - base);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rsp_cnt   = 0;
        req_run   = 0;
        force_en  = 1'b0;
        force_op  = 2'd0;
        ram_qa    = 16'h0000;
        ram_op    = 2'd0;
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr  = 6'h00;
        cmd_wdata = 16'h0000;
        rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 16'h0000;
            ram_mem[i] = 16'h0000;
        end
        test_reset();
        test_write_read();
        test_latency();
        test_back_to_back();
        test_err();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
